// File: rtl/peripheral_apb2ahb3.sv
// APB-slave to AHB-Lite-master bridge: each accepted APB transfer becomes one
// AHB-Lite SINGLE transfer, one transfer outstanding at a time, all on HCLK.
module peripheral_apb2ahb3 #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned PADDR_SIZE = 10,
  parameter int unsigned PDATA_SIZE = 8,
  parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
  input  logic                  HRESETn,
  input  logic                  HCLK,
  // APB slave side
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic [2:0]            PPROT,
  input  logic                  PWRITE,
  input  logic                  PSTRB,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [PDATA_SIZE-1:0] PWDATA,
  output logic [PDATA_SIZE-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  // AHB-Lite master side
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int unsigned LANES    = HDATA_SIZE / PDATA_SIZE;
  localparam int unsigned LANE_LSB = $clog2(PDATA_SIZE / 8);
  localparam int unsigned LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [2:0]  SIZE_ENC = 3'(LANE_LSB);
  // Upper part of the AHB window; the low PADDR_SIZE bits come from PADDR.
  localparam logic [HADDR_SIZE-1:0] BASE_HI =
    HADDR_BASE & ({HADDR_SIZE{1'b1}} << PADDR_SIZE);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t                state;
  logic [LANE_W-1:0]     lane_c;
  logic [PDATA_SIZE-1:0] rd_lane_c;
  logic                  unused_pprot;

  // PPROT[1] (secure/non-secure) has no AHB-Lite counterpart.
  assign unused_pprot = PPROT[1];

  // Burst type and lock are fixed: only SINGLE, never locked.
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

  // Select the APB-wide byte lane of HRDATA addressed by the latched HADDR.
  always_comb begin
    lane_c    = (LANES > 1) ? LANE_W'(HADDR >> LANE_LSB) : '0;
    rd_lane_c = PDATA_SIZE'(HRDATA >> (32'(lane_c) * PDATA_SIZE));
  end

  // Bridge FSM with registered APB and AHB outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      HADDR   <= '0;
      HWDATA  <= '0;
      HWRITE  <= 1'b0;
      HSIZE   <= 3'b000;
      HPROT   <= 4'b0000;
      HTRANS  <= HTRANS_IDLE;
      PRDATA  <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            HADDR  <= BASE_HI | HADDR_SIZE'(PADDR);
            HWRITE <= PWRITE;
            HSIZE  <= SIZE_ENC;
            HPROT  <= {2'b00, PPROT[0], ~PPROT[2]};
            HWDATA <= {LANES{PWDATA}};
            if (PWRITE && !PSTRB) begin
              // Write with no strobes: nothing to do on AHB, complete at once.
              PREADY  <= 1'b1;
              PSLVERR <= 1'b0;
              state   <= ST_RESP;
            end else begin
              HTRANS <= HTRANS_NONSEQ;
              state  <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            HTRANS <= HTRANS_IDLE;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // First cycle of a two-cycle ERROR (HREADY low) is simply waited out.
          if (HREADY) begin
            if (!HWRITE) begin
              PRDATA <= rd_lane_c;
            end
            PSLVERR <= HRESP;
            PREADY  <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
